// File: rtl/aer_pkg.sv
// Shared types and helpers for the LIF address-event encoder.
package aer_pkg;

    localparam int unsigned AER_TS_WIDTH_DEF  = 16;
    localparam int unsigned AER_N_NEURONS_DEF = 8;

    // Address width for a neuron bank, never narrower than one bit.
    function automatic int unsigned aer_addr_w(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned AER_ADDR_W_DEF = aer_addr_w(AER_N_NEURONS_DEF);

    // Event payload for the default bank configuration.
    typedef struct packed {
        logic [AER_ADDR_W_DEF-1:0]   addr;
        logic [AER_TS_WIDTH_DEF-1:0] ts;
    } aer_event_t;

endpackage

// File: rtl/aer_fifo.sv
// Show-ahead event FIFO with a registered head so idle outputs hold the last entry.
module aer_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    // Pointer/count update and next head selection (bypass when writing the head slot).
    always_comb begin
        do_push  = push && !full_q;
        do_pop   = pop && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
        if (!empty_d) begin
            head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
        end
    end

    // Storage array; contents are only meaningful behind the count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            head_q   <= head_d;
        end
    end

    assign head  = head_q;
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/lif_aer_encoder.sv
// Captures LIF spike pulses, arbitrates round-robin and queues {addr, ts} events.
module lif_aer_encoder
    import aer_pkg::*;
#(
    parameter int unsigned N_NEURONS  = AER_N_NEURONS_DEF,
    parameter int unsigned TS_WIDTH   = AER_TS_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DROP_WIDTH = 16,
    localparam int unsigned ADDR_W    = aer_addr_w(N_NEURONS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ts_clr,
    input  logic [N_NEURONS-1:0]  spike_in,
    output logic                  ev_valid,
    input  logic                  ev_ready,
    output logic [ADDR_W-1:0]     ev_addr,
    output logic [TS_WIDTH-1:0]   ev_ts,
    output logic                  fifo_full,
    output logic [DROP_WIDTH-1:0] drop_cnt
);

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned NDROP_W = ADDR_W + 1;
    localparam int unsigned SUM_W   = ((DROP_WIDTH > NDROP_W) ? DROP_WIDTH : NDROP_W) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [TS_WIDTH-1:0] ts;
    } event_t;

    localparam int unsigned EV_W = $bits(event_t);

    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [N_NEURONS-1:0]  pending_q, pending_d;
    logic [TS_WIDTH-1:0]   ts_store_q [N_NEURONS];
    logic [TS_WIDTH-1:0]   ts_store_d [N_NEURONS];
    logic [ADDR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;

    logic                  pick_found;
    logic [ADDR_W-1:0]     pick_idx;
    logic                  grant;
    logic [N_NEURONS-1:0]  grant_vec;
    logic [NDROP_W-1:0]    drops;
    logic [SUM_W-1:0]      drop_sum;
    event_t                push_ev;
    event_t                head_ev;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;

    // First pending index at or after start, wrapping to 0; MSB flags a hit.
    function automatic logic [ADDR_W:0] rr_pick(input logic [N_NEURONS-1:0] pend,
                                                input logic [ADDR_W-1:0]    start);
        logic              found;
        logic [ADDR_W-1:0] idx;
        logic [31:0]       j;
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int unsigned k = 0; k < N_NEURONS; k++) begin
            j = 32'(start) + k;
            if (j >= N_NEURONS) j = j - N_NEURONS;
            if (!found && pend[j[ADDR_W-1:0]]) begin
                found = 1'b1;
                idx   = j[ADDR_W-1:0];
            end
        end
        return {found, idx};
    endfunction

    // Timestamp, arbitration, capture and drop accounting.
    always_comb begin
        ts_d       = ts_clr ? '0 : ts_q + TS_WIDTH'(1);
        pending_d  = pending_q;
        ts_store_d = ts_store_q;
        rr_ptr_d   = rr_ptr_q;
        drops      = '0;

        {pick_found, pick_idx} = rr_pick(pending_q, rr_ptr_q);
        grant        = pick_found && (fifo_count < CNT_W'(FIFO_DEPTH));
        grant_vec    = grant ? (N_NEURONS'(1) << pick_idx) : '0;
        push_ev.addr = pick_idx;
        push_ev.ts   = ts_store_q[pick_idx];

        if (grant) begin
            rr_ptr_d = (pick_idx == ADDR_W'(N_NEURONS - 1)) ? '0 : pick_idx + ADDR_W'(1);
        end

        for (int i = 0; i < N_NEURONS; i++) begin
            if (grant_vec[i]) pending_d[i] = 1'b0;
            if (spike_in[i]) begin
                if (!pending_q[i] || grant_vec[i]) begin
                    pending_d[i]  = 1'b1;
                    ts_store_d[i] = ts_q;
                end else begin
                    drops = drops + NDROP_W'(1);
                end
            end
        end

        drop_sum = SUM_W'(drop_q) + SUM_W'(drops);
        drop_d   = (drop_sum[SUM_W-1:DROP_WIDTH] != '0) ? '1 : drop_sum[DROP_WIDTH-1:0];
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q      <= '0;
            pending_q <= '0;
            rr_ptr_q  <= '0;
            drop_q    <= '0;
            for (int i = 0; i < N_NEURONS; i++) ts_store_q[i] <= '0;
        end else begin
            ts_q       <= ts_d;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            drop_q     <= drop_d;
            ts_store_q <= ts_store_d;
        end
    end

    aer_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .push_data (push_ev),
        .pop       (!fifo_empty && ev_ready),
        .head      (head_ev),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign ev_valid = !fifo_empty;
    assign ev_addr  = head_ev.addr;
    assign ev_ts    = head_ev.ts;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_lif_aer_encoder.sv
// Directed bench for lif_aer_encoder; a second instance has a 4-bit timestamp and 2-bit drop counter.
module tb_lif_aer_encoder;

    logic        clk;
    logic        rst;
    logic        ts_clr;
    logic [7:0]  spike_in;
    logic        ev_ready;

    logic        ev_valid;
    logic [2:0]  ev_addr;
    logic [15:0] ev_ts;
    logic        fifo_full;
    logic [15:0] drop_cnt;

    logic        ev_valid4;
    logic [2:0]  ev_addr4;
    logic [3:0]  ev_ts4;
    logic        fifo_full4;
    logic [1:0]  drop_cnt4;

    int checks = 0;
    int errors = 0;

    lif_aer_encoder u_dut (
        .clk       (clk),
        .rst       (rst),
        .ts_clr    (ts_clr),
        .spike_in  (spike_in),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_addr   (ev_addr),
        .ev_ts     (ev_ts),
        .fifo_full (fifo_full),
        .drop_cnt  (drop_cnt)
    );

    lif_aer_encoder #(.TS_WIDTH(4), .DROP_WIDTH(2)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .ts_clr    (ts_clr),
        .spike_in  (spike_in),
        .ev_valid  (ev_valid4),
        .ev_ready  (ev_ready),
        .ev_addr   (ev_addr4),
        .ev_ts     (ev_ts4),
        .fifo_full (fifo_full4),
        .drop_cnt  (drop_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ev(input string tag, input logic [31:0] addr, input logic [31:0] ts);
        chk({tag, "_valid"}, 32'(ev_valid), 32'd1);
        chk({tag, "_addr"},  32'(ev_addr),  addr);
        chk({tag, "_ts"},    32'(ev_ts),    ts);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Leaves the bench at a negedge with rst released and ts = 0 in this cycle.
    task automatic do_reset();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        ts_clr   = 1'b0;
        spike_in = '0;
        ev_ready = 1'b0;
        repeat (2) nxt();

        chk("rst_valid", 32'(ev_valid),  32'd0);
        chk("rst_addr",  32'(ev_addr),   32'd0);
        chk("rst_ts",    32'(ev_ts),     32'd0);
        chk("rst_full",  32'(fifo_full), 32'd0);
        chk("rst_drop",  32'(drop_cnt),  32'd0);
        rst = 1'b0;

        // Single spike on neuron 5 at ts=100
        ev_ready = 1'b1;
        repeat (100) nxt();
        spike_in = 8'h20;
        nxt();
        spike_in = '0;
        chk("t1_lat1", 32'(ev_valid), 32'd0);
        nxt();
        chk_ev("t1_ev", 32'd5, 32'd100);
        nxt();
        chk("t1_once", 32'(ev_valid), 32'd0);
        chk("t1_drop", 32'(drop_cnt), 32'd0);

        // All neurons at ts=20, drained in index order
        do_reset();
        repeat (20) nxt();
        spike_in = 8'hFF;
        nxt();
        spike_in = '0;
        chk("t2_lat1", 32'(ev_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            nxt();
            chk_ev("t2_ev", 32'(k), 32'd20);
        end
        nxt();
        chk("t2_empty", 32'(ev_valid), 32'd0);
        // rr pointer back at 0: neuron 0 wins over 7
        spike_in = 8'h81;
        nxt();
        spike_in = '0;
        nxt();
        chk_ev("t2_rr0", 32'd0, 32'd30);
        nxt();
        chk_ev("t2_rr7", 32'd7, 32'd30);

        // Fill FIFO, then 8 spikes on neuron 3: one re-pends, 7 dropped
        do_reset();
        ev_ready = 1'b0;
        spike_in = 8'hFF;
        nxt();
        spike_in = '0;
        repeat (8) nxt();
        chk("t3_full", 32'(fifo_full), 32'd1);
        chk_ev("t3_head", 32'd0, 32'd0);
        spike_in = 8'h08;
        repeat (8) nxt();
        spike_in = '0;
        chk("t3_drop",     32'(drop_cnt),  32'd7);
        chk("t3_drop_sat", 32'(drop_cnt4), 32'd3);
        chk("t3_hold",     32'(ev_addr),   32'd0);
        chk("t3_full2",    32'(fifo_full), 32'd1);
        ev_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk_ev("t3_drain", 32'(k), 32'd0);
            nxt();
        end
        chk_ev("t3_late3", 32'd3, 32'd9);
        nxt();
        chk("t3_empty", 32'(ev_valid), 32'd0);

        // Neuron 2: capture at ts=10, drop at ts=11, re-set on same-cycle grant at ts=13
        do_reset();
        ev_ready = 1'b0;
        spike_in = 8'hFF;
        nxt();
        spike_in = '0;
        repeat (9) nxt();
        spike_in = 8'h04;
        repeat (2) nxt();
        spike_in = '0;
        chk("t4_drop1", 32'(drop_cnt), 32'd1);
        ev_ready = 1'b1;
        chk_ev("t4_head0", 32'd0, 32'd0);
        nxt();
        spike_in = 8'h04;
        nxt();
        spike_in = '0;
        chk("t4_nodrop", 32'(drop_cnt), 32'd1);
        chk_ev("t4_head2", 32'd2, 32'd0);
        repeat (6) nxt();
        chk_ev("t4_ev10", 32'd2, 32'd10);
        nxt();
        chk_ev("t4_ev13", 32'd2, 32'd13);
        nxt();
        chk("t4_empty", 32'(ev_valid), 32'd0);
        chk("t4_drop2", 32'(drop_cnt), 32'd1);

        // Timestamp wrap on 4-bit instance, then ts_clr
        do_reset();
        ev_ready = 1'b1;
        repeat (16) nxt();
        spike_in = 8'h10;
        nxt();
        spike_in = '0;
        nxt();
        chk("t5_valid4", 32'(ev_valid4), 32'd1);
        chk("t5_addr4",  32'(ev_addr4),  32'd4);
        chk("t5_wrap4",  32'(ev_ts4),    32'd0);
        chk_ev("t5_ts16", 32'd4, 32'd16);
        nxt();
        ts_clr = 1'b1;
        nxt();
        ts_clr = 1'b0;
        repeat (5) nxt();
        spike_in = 8'h40;
        nxt();
        spike_in = '0;
        nxt();
        chk_ev("t5_clr", 32'd6, 32'd5);
        chk("t5_clr4", 32'(ev_ts4), 32'd5);
        nxt();
        chk("t5_empty", 32'(ev_valid), 32'd0);

        // Reset with 4 buffered, 2 pending and a two-drop cycle behind us
        do_reset();
        ev_ready = 1'b0;
        spike_in = 8'h3F;
        nxt();
        spike_in = 8'h30;
        nxt();
        spike_in = '0;
        chk("t6_multidrop", 32'(drop_cnt), 32'd2);
        repeat (3) nxt();
        chk_ev("t6_buffered", 32'd0, 32'd0);
        rst = 1'b1;
        nxt();
        chk("t6_rst_valid", 32'(ev_valid),  32'd0);
        chk("t6_rst_drop",  32'(drop_cnt),  32'd0);
        chk("t6_rst_full",  32'(fifo_full), 32'd0);
        rst = 1'b0;
        ev_ready = 1'b1;
        spike_in = 8'h02;
        nxt();
        spike_in = '0;
        chk("t6_lat1", 32'(ev_valid), 32'd0);
        nxt();
        chk_ev("t6_fresh", 32'd1, 32'd0);
        nxt();
        chk("t6_one", 32'(ev_valid), 32'd0);
        repeat (4) nxt();
        chk("t6_nostale", 32'(ev_valid), 32'd0);
        chk("t6_drop",    32'(drop_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lif_aer_encoder.md
Name: lif_aer_encoder

Overview:
Collects single-cycle spike pulses from a bank of N LIF neurons and serialises them into address-event (AER) packets. Each packet carries the neuron index and a timestamp. Sits directly downstream of the neuron array and feeds the event bus / router over a valid/ready handshake. Spikes that cannot be buffered are dropped and counted.

Parameters:
N_NEURONS, 8, number of neuron spike inputs (2..256)
TS_WIDTH, 16, timestamp counter width
FIFO_DEPTH, 8, event FIFO entries (power of 2, >=2)
DROP_WIDTH, 16, width of saturating drop counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ts_clr  in  1  synchronous timestamp clear
spike_in  in  N_NEURONS  per-neuron spike pulses (one bit per neuron)
ev_valid  out  1  event available at FIFO head
ev_ready  in  1  consumer accepts event
ev_addr  out  ADDR_W  neuron index of head event (ADDR_W = max(1,$clog2(N_NEURONS)))
ev_ts  out  TS_WIDTH  timestamp of head event
fifo_full  out  1  FIFO holds FIFO_DEPTH entries
drop_cnt  out  DROP_WIDTH  saturating count of dropped spikes

Behaviour:
- Reset: ts counter 0, all pending bits 0, stored timestamps 0, rr pointer 0, FIFO empty. Outputs: ev_valid=0, ev_addr=0, ev_ts=0, fifo_full=0, drop_cnt=0. Reset mid-operation discards pending and buffered events; no partial packet ever appears.
- Timestamp: ts increments by 1 every cycle and wraps modulo 2^TS_WIDTH. ts_clr=1 loads 0 at the next edge, overriding the increment.
- Capture: at each edge, for every i with spike_in[i]=1:
  - if pending[i]=0, or pending[i] is granted this same cycle: set pending[i]=1 and ts_store[i]=current ts (pre-increment value).
  - if pending[i]=1 and is not granted this cycle: the spike is dropped and drop_cnt increments.
- Drop counting: multiple drops in one cycle add their count. drop_cnt saturates at all-ones and never wraps.
- Arbitration: combinational round-robin over pending bits. The search starts at rr_ptr and wraps to 0.
  - A grant occurs only when at least one bit is pending and the FIFO is not full (registered count < FIFO_DEPTH). A pop in the same cycle does not free space for a push.
  - On grant of index g: push {g, ts_store[g]}, clear pending[g] (unless re-set per the capture rule above), and set rr_ptr = (g+1) mod N_NEURONS.
  - At most one push per cycle.
- FIFO: synchronous show-ahead.
  - ev_valid = !empty; ev_addr/ev_ts reflect the head entry.
  - A pop occurs when ev_valid && ev_ready. Push and pop in the same cycle leave the count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - ev_addr/ev_ts are held stable while ev_valid && !ev_ready.
  - When empty, ev_addr/ev_ts hold the last value; consumers must ignore them.
- Latency: spike_in high in the cycle before edge E0 → pending set at E0 → pushed at E1 (if granted) → ev_valid=1 in the cycle after E1. Minimum latency is 2 cycles. ev_ts equals the ts value present in the spike cycle.
- Throughput: one event per cycle when ev_ready is held at 1.
- fifo_full is registered from count == FIFO_DEPTH.

Decomposition:
- Package aer_pkg:
  - function to derive ADDR_W
  - typedef aer_event_t (packed struct: addr, ts)
  - localparam for default TS_WIDTH
- Sub-module aer_fifo:
  - parameterised on element type width and depth
  - push/pop/full/empty/count interface
- Round-robin pick is a function inside lif_aer_encoder; it is not a separate module.

Test Plan:
1. Single spike on neuron 5 at ts=100, ev_ready=1 → exactly one event {addr=5, ts=100} with ev_valid high 2 cycles after the spike; drop_cnt=0.
2. All 8 spike_in bits high for one cycle at ts=20, rr_ptr=0, ev_ready=1 → events addr 0,1,...,7 on consecutive cycles, all ts=20; rr_ptr ends at 0.
3. ev_ready=0, spikes on neurons 0..7 with FIFO_DEPTH=8, then 8 more single spikes on neuron 3 → FIFO fills (fifo_full=1). Neuron 3 re-pends once; subsequent spikes on neuron 3 increment drop_cnt by 1 each (7 total). After ev_ready=1, the 8 buffered events drain, then {3, first-dropped-free ts}.
4. Neuron 2 spikes at ts=10 and ts=11 while ev_ready=0 and FIFO full → first spike captured, second dropped (drop_cnt=1). Same-cycle grant plus new spike on neuron 2 → no drop; new ts stored.
5. Set TS_WIDTH=4. Run 17 cycles and spike at cycle 16 → ev_ts=0 (wrap). Pulse ts_clr → next spike reports ts counted from 0.
6. Assert rst while 4 events are buffered and 2 are pending → next cycle ev_valid=0, drop_cnt=0, fifo_full=0. After release, a spike on neuron 1 produces only {1, ts} with no stale events.
